// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one data-memory port between num_req_p
// cores. Request and response handshakes are relayed combinationally between
// the granted core and the memory. A watchdog aborts stalled transactions and
// raises a sticky timeout flag.
//
// Packed field layout (MSB first):
//   mem_in_s  (36 bits): write_data[35:4], valid[3], wen[2], byte_not_word[1], yumi[0]
//   mem_out_s (34 bits): read_data[33:2], valid[1], yumi[0]
module dmem_arbiter #(
  parameter int num_req_p = 2,
  parameter int timeout_p = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [num_req_p-1:0][35:0]   req_i,
  input  logic [num_req_p-1:0][31:0]   req_addr_i,
  output logic [num_req_p-1:0][33:0]   resp_o,
  output logic [35:0]                  mem_o,
  output logic [31:0]                  mem_addr_o,
  input  logic [33:0]                  mem_i,
  output logic [num_req_p-1:0]         grant_o,
  output logic                         timeout_o
);

  localparam int idx_w_lp = $clog2(num_req_p);
  localparam int wd_w_lp  = $clog2(timeout_p + 1);

  localparam int in_valid_lp = 3;
  localparam int in_yumi_lp  = 0;
  localparam int out_valid_lp = 1;
  localparam int out_yumi_lp  = 0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]          state_r, state_n;
  logic [idx_w_lp-1:0] grant_r, grant_n;
  logic [idx_w_lp-1:0] rr_ptr_r, rr_ptr_n;
  logic [wd_w_lp-1:0]  wd_cnt_r;

  logic [35:0]         req_g;
  logic [idx_w_lp-1:0] grant_inc;
  logic                scan_hit;
  logic [idx_w_lp-1:0] scan_idx;
  logic                busy;
  logic                req_accept;
  logic                resp_done;
  logic                expire;

  assign req_g      = req_i[grant_r];
  assign grant_inc  = (grant_r == idx_w_lp'(num_req_p - 1)) ? '0 : grant_r + 1'b1;
  assign busy       = (state_r == REQ) || (state_r == RESP);
  assign req_accept = (state_r == REQ) && mem_i[out_yumi_lp];
  assign resp_done  = (state_r == RESP) && mem_i[out_valid_lp] && req_g[in_yumi_lp];
  // A completing handshake always beats the watchdog on the same cycle.
  assign expire     = busy && (wd_cnt_r == wd_w_lp'(timeout_p)) && !req_accept && !resp_done;

  // Find the first valid requester at or after the round-robin pointer.
  // Scanning from the far end lets the nearest hit overwrite the others.
  always_comb begin
    int j;
    logic [idx_w_lp-1:0] cand;
    j        = 0;
    cand     = '0;
    scan_hit = 1'b0;
    scan_idx = rr_ptr_r;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      j = int'(rr_ptr_r) + i;
      if (j >= num_req_p) j = j - num_req_p;
      cand = idx_w_lp'(j);
      if (req_i[cand][in_valid_lp]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // Next-state logic: grant in IDLE, then follow the request and response
  // handshakes, returning to IDLE on completion, withdrawal or watchdog abort.
  always_comb begin
    state_n  = state_r;
    grant_n  = grant_r;
    rr_ptr_n = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (scan_hit) begin
          state_n = REQ;
          grant_n = scan_idx;
        end
      end
      REQ: begin
        if (req_accept) begin
          state_n = RESP;
        end else if (expire || !req_g[in_valid_lp]) begin
          state_n  = IDLE;
          rr_ptr_n = grant_inc;
        end
      end
      RESP: begin
        if (resp_done || expire) begin
          state_n  = IDLE;
          rr_ptr_n = grant_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers, watchdog counter (held at its limit rather than wrapping)
  // and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      rr_ptr_r  <= '0;
      wd_cnt_r  <= '0;
      timeout_o <= 1'b0;
    end else begin
      state_r  <= state_n;
      grant_r  <= grant_n;
      rr_ptr_r <= rr_ptr_n;
      if (state_r == IDLE) begin
        wd_cnt_r <= '0;
      end else if (wd_cnt_r != wd_w_lp'(timeout_p)) begin
        wd_cnt_r <= wd_cnt_r + 1'b1;
      end
      if (expire) begin
        timeout_o <= 1'b1;
      end
    end
  end

  // Output steering: only the granted slot sees the memory, everything else
  // (and everything in IDLE) is held at zero.
  always_comb begin
    mem_o      = '0;
    mem_addr_o = '0;
    resp_o     = '0;
    grant_o    = '0;
    case (state_r)
      REQ: begin
        mem_o                           = req_g;
        mem_o[in_yumi_lp]               = 1'b0;
        mem_addr_o                      = req_addr_i[grant_r];
        resp_o[grant_r][out_yumi_lp]    = mem_i[out_yumi_lp];
        grant_o                         = num_req_p'(1) << grant_r;
      end
      RESP: begin
        mem_o                           = req_g;
        mem_o[in_valid_lp]              = 1'b0;
        mem_o[in_yumi_lp]               = req_g[in_yumi_lp] & ~expire;
        mem_addr_o                      = req_addr_i[grant_r];
        resp_o[grant_r][out_valid_lp]   = mem_i[out_valid_lp];
        resp_o[grant_r][33:2]           = mem_i[33:2];
        grant_o                         = num_req_p'(1) << grant_r;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios with a small reactive memory
// model and a queue-based scoreboard checked by an independent monitor.
module tb_dmem_arbiter;

  localparam int N  = 2;
  localparam int TO = 4;

  typedef struct {
    int          slot;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] data;
  } req_exp_t;

  typedef struct {
    int          slot;
    logic [31:0] data;
  } resp_exp_t;

  logic clk = 1'b0;
  logic reset;

  logic [N-1:0][35:0] req;
  logic [N-1:0][31:0] req_addr;
  logic [N-1:0][33:0] resp;
  logic [35:0]        mem_req;
  logic [31:0]        mem_addr;
  logic [33:0]        mem_resp;
  logic [N-1:0]       grant;
  logic               timeout;

  logic [N-1:0] core_valid, core_wen, core_yumi;
  logic [31:0]  core_data [N];
  logic [31:0]  core_addr [N];

  logic         mem_yumi, mem_valid, mem_stall;
  logic [31:0]  mem_rdata;

  req_exp_t  req_q[$];
  resp_exp_t resp_q[$];
  int checks = 0;
  int fails = 0;
  int resp_seen = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req[k]      = {core_data[k], core_valid[k], core_wen[k], 1'b0, core_yumi[k]};
      req_addr[k] = core_addr[k];
    end
  end

  assign mem_resp = {mem_rdata, mem_valid, mem_yumi};

  dmem_arbiter #(.num_req_p(N), .timeout_p(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .req_addr_i (req_addr),
    .resp_o     (resp),
    .mem_o      (mem_req),
    .mem_addr_o (mem_addr),
    .mem_i      (mem_resp),
    .grant_o    (grant),
    .timeout_o  (timeout)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h20) ? 32'h1234_5678 : (32'h1000_0000 | a);
  endfunction

  function automatic logic [N-1:0] one_hot(input int s);
    logic [N-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int slot, input logic valid, input logic wen,
                               input logic [31:0] addr, input logic [31:0] data);
    core_valid[slot] = valid;
    core_wen[slot]   = wen;
    core_addr[slot]  = addr;
    core_data[slot]  = data;
  endtask

  task automatic expect_txn(input int slot, input logic [31:0] addr, input logic wen,
                            input logic [31:0] wdata, input logic [31:0] rdata);
    req_exp_t  r;
    resp_exp_t p;
    r.slot = slot; r.addr = addr; r.wen = wen; r.data = wdata;
    p.slot = slot; p.data = rdata;
    req_q.push_back(r);
    resp_q.push_back(p);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory model: accepts a request one cycle when idle, answers the next.
  // Handshakes are observed at negedge and acted on just after the posedge.
  initial begin
    logic        acc, done, rs, acc_wen, pending;
    logic [31:0] acc_addr, pend_data;
    mem_yumi = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    pending = 1'b0; pend_data = '0;
    forever begin
      @(negedge clk);
      acc      = mem_req[3] && mem_yumi;
      done     = mem_valid && mem_req[0];
      rs       = reset;
      acc_wen  = mem_req[2];
      acc_addr = mem_addr;
      @(posedge clk);
      #2;
      if (rs) begin
        pending = 1'b0;
      end else begin
        if (done) pending = 1'b0;
        if (acc) begin
          pending   = 1'b1;
          pend_data = acc_wen ? 32'h0 : mem_data(acc_addr);
        end
      end
      mem_yumi  = !mem_stall && mem_req[3] && !pending;
      mem_valid = !mem_stall && pending;
      mem_rdata = mem_valid ? pend_data : 32'h0;
    end
  end

  // Monitor: pops the scoreboard on every request and response handshake.
  initial begin
    req_exp_t  e;
    resp_exp_t p;
    forever begin
      @(negedge clk);
      if (mem_req[3] && mem_yumi) begin
        if (req_q.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected_req: got addr 0x%0h, expected no request", mem_addr);
        end else begin
          e = req_q.pop_front();
          checkOutput("req_grant", 64'(grant), 64'(one_hot(e.slot)));
          checkOutput("req_addr", 64'(mem_addr), 64'(e.addr));
          checkOutput("req_wen", 64'(mem_req[2]), 64'(e.wen));
          checkOutput("req_wdata", 64'(mem_req[35:4]), 64'(e.data));
        end
      end
      for (int k = 0; k < N; k++) begin
        if (resp[k][1] && core_yumi[k]) begin
          resp_seen++;
          if (resp_q.size() == 0) begin
            checks++; fails++;
            $display("[TB] FAIL unexpected_resp: got slot %0d, expected no response", k);
          end else begin
            p = resp_q.pop_front();
            checkOutput("resp_slot", 64'(k), 64'(p.slot));
            checkOutput("resp_rdata", 64'(resp[k][33:2]), 64'(p.data));
          end
        end
      end
    end
  end

  // Directed scenarios.
  initial begin
    int bound;
    reset = 1'b1; mem_stall = 1'b0;
    core_valid = '0; core_wen = '0; core_yumi = '1;
    for (int k = 0; k < N; k++) begin core_data[k] = '0; core_addr[k] = '0; end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_grant", 64'(grant), 64'h0);
    checkOutput("reset_timeout", 64'(timeout), 64'h0);
    checkOutput("reset_mem", 64'(mem_req), 64'h0);
    checkOutput("reset_addr", 64'(mem_addr), 64'h0);
    checkOutput("reset_resp0", 64'(resp[0]), 64'h0);
    checkOutput("reset_resp1", 64'(resp[1]), 64'h0);
    tick;
    reset = 1'b0;

    // Round-robin: both slots continuously valid.
    $display("[TB] round-robin");
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h44, 32'h0);
    for (int n = 0; n < 2; n++) begin
      expect_txn(0, 32'h40, 1'b0, 32'h0, 32'h1000_0040);
      expect_txn(1, 32'h44, 1'b0, 32'h0, 32'h1000_0044);
    end
    for (int n = 0; n < 4; n++) begin
      tick;
      @(negedge clk);
      checkOutput("rr_grant", 64'(grant), 64'(one_hot(n % 2)));
      tick;
      if (n == 3) begin core_valid[0] = 1'b0; core_valid[1] = 1'b0; end
      tick;
    end
    @(negedge clk);
    checkOutput("rr_idle_grant", 64'(grant), 64'h0);
    checkOutput("rr_resp_count", 64'(resp_seen), 64'd4);

    // Response routing to slot 1.
    $display("[TB] response routing");
    tick;
    applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
    expect_txn(1, 32'h20, 1'b0, 32'h0, 32'h1234_5678);
    tick; @(negedge clk);
    checkOutput("route_grant", 64'(grant), 64'(one_hot(1)));
    checkOutput("route_addr", 64'(mem_addr), 64'h20);
    tick; @(negedge clk);
    checkOutput("route_resp1", 64'(resp[1]), 64'({32'h1234_5678, 1'b1, 1'b0}));
    checkOutput("route_resp0", 64'(resp[0]), 64'h0);
    tick;
    core_valid[1] = 1'b0;

    // Single store from slot 0.
    $display("[TB] single store");
    tick;
    applyStimulus(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    expect_txn(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    checkOutput("store_not_yet", 64'(mem_req[3]), 64'h0);
    tick; @(negedge clk);
    checkOutput("store_valid", 64'(mem_req[3]), 64'h1);
    checkOutput("store_addr", 64'(mem_addr), 64'h10);
    checkOutput("store_grant_req", 64'(grant), 64'h1);
    checkOutput("store_core_yumi", 64'(resp[0][0]), 64'h1);
    tick; @(negedge clk);
    checkOutput("store_grant_resp", 64'(grant), 64'h1);
    checkOutput("store_resp_valid", 64'(resp[0][1]), 64'h1);
    checkOutput("store_mem_yumi", 64'(mem_req[0]), 64'h1);
    checkOutput("store_valid_low", 64'(mem_req[3]), 64'h0);
    checkOutput("store_addr_held", 64'(mem_addr), 64'h10);
    tick;
    core_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("store_idle", 64'(grant), 64'h0);

    // Withdraw: slot 0 drops valid while the memory stalls.
    $display("[TB] withdraw");
    tick;
    mem_stall = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h50, 32'h0);
    tick; @(negedge clk);
    checkOutput("wd_req_grant", 64'(grant), 64'h1);
    checkOutput("wd_req_valid", 64'(mem_req[3]), 64'h1);
    tick;
    core_valid[0] = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 32'h54, 32'h0);
    expect_txn(1, 32'h54, 1'b0, 32'h0, 32'h1000_0054);
    @(negedge clk);
    checkOutput("wd_valid_gone", 64'(mem_req[3]), 64'h0);
    tick;
    mem_stall = 1'b0;
    @(negedge clk);
    checkOutput("wd_idle_grant", 64'(grant), 64'h0);
    checkOutput("wd_idle_valid", 64'(mem_req[3]), 64'h0);
    tick; @(negedge clk);
    checkOutput("wd_next_grant", 64'(grant), 64'(one_hot(1)));
    tick; tick;
    core_valid[1] = 1'b0;

    // Watchdog: memory never accepts, then recovers.
    $display("[TB] watchdog");
    tick;
    mem_stall = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h60, 32'h0);
    tick; @(negedge clk);
    checkOutput("to_req_grant", 64'(grant), 64'h1);
    checkOutput("to_not_yet", 64'(timeout), 64'h0);
    repeat (4) tick;
    @(negedge clk);
    checkOutput("to_abort_grant", 64'(grant), 64'h1);
    checkOutput("to_abort_flag", 64'(timeout), 64'h0);
    checkOutput("to_abort_yumi", 64'(resp[0][0]), 64'h0);
    tick;
    expect_txn(0, 32'h60, 1'b0, 32'h0, 32'h1000_0060);
    mem_stall = 1'b0;
    @(negedge clk);
    checkOutput("to_flag", 64'(timeout), 64'h1);
    checkOutput("to_idle", 64'(grant), 64'h0);
    tick; @(negedge clk);
    checkOutput("to_regrant", 64'(grant), 64'h1);
    tick; tick;
    core_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("to_sticky", 64'(timeout), 64'h1);

    // Reset in the middle of RESP.
    $display("[TB] reset mid-RESP");
    tick;
    core_yumi[1] = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 32'h70, 32'h0);
    req_q.push_back('{slot: 1, addr: 32'h70, wen: 1'b0, data: 32'h0});
    tick; @(negedge clk);
    checkOutput("rst_req_grant", 64'(grant), 64'(one_hot(1)));
    tick; @(negedge clk);
    checkOutput("rst_resp_valid", 64'(resp[1][1]), 64'h1);
    tick;
    reset = 1'b1;
    core_valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("rst_still_resp", 64'(grant), 64'(one_hot(1)));
    tick; @(negedge clk);
    checkOutput("rst_grant", 64'(grant), 64'h0);
    checkOutput("rst_timeout", 64'(timeout), 64'h0);
    checkOutput("rst_mem", 64'(mem_req), 64'h0);
    checkOutput("rst_addr", 64'(mem_addr), 64'h0);
    checkOutput("rst_resp1", 64'(resp[1]), 64'h0);
    tick;
    reset = 1'b0;
    core_yumi[1] = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h80, 32'h0);
    expect_txn(0, 32'h80, 1'b0, 32'h0, 32'h1000_0080);
    tick; @(negedge clk);
    checkOutput("rst_after_grant", 64'(grant), 64'h1);
    tick; tick;
    core_valid[0] = 1'b0;

    // Drain with a bounded wait.
    bound = 0;
    while (resp_seen < 9 && bound < 20) begin
      tick;
      bound++;
    end
    checkOutput("resp_total", 64'(resp_seen), 64'd9);
    checkOutput("req_q_empty", 64'(req_q.size()), 64'd0);
    checkOutput("resp_q_empty", 64'(resp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares one data-memory port between `num_req_p` cores. Each core's data-memory interface (`mem_in_s`/`mem_out_s` plus `data_mem_addr`) lands on a requester slot. The arbiter grants one transaction at a time in round-robin order and relays the request (valid/yumi) and response (valid/yumi) handshakes between the granted core and the memory. A watchdog flags a transaction whose memory side stalls too long.

## Interface
- `num_req_p`, default 2: number of requester slots, 2..8.
- `timeout_p`, default 255: max cycles a granted transaction may stay in REQ+RESP before abort; >=1.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `req_i`  in  `mem_in_s` x num_req_p: per-core request (write_data, valid, wen, byte_not_word, yumi).
- `req_addr_i`  in  32 x num_req_p: per-core byte address (core `data_mem_addr`).
- `resp_o`  out  `mem_out_s` x num_req_p: per-core response (read_data, valid, yumi).
- `mem_o`  out  `mem_in_s`: request to data memory.
- `mem_addr_o`  out  32: address to data memory.
- `mem_i`  in  `mem_out_s`: response from data memory.
- `grant_o`  out  num_req_p: one-hot current owner; 0 in IDLE.
- `timeout_o`  out  1: sticky watchdog flag.

## Operation
- Registers:
  - state_r in {IDLE, REQ, RESP};
  - grant_r, an index of $clog2(num_req_p) bits;
  - rr_ptr_r, same width;
  - wd_cnt_r, $clog2(timeout_p+1) bits;
  - timeout_o.
- **IDLE.** Scan `req_i[k].valid` starting at rr_ptr_r, wrapping modulo num_req_p. On the first hit k, set grant_r <= k and go to REQ. If no requester is valid, stay in IDLE. All outputs are inactive.
- **REQ.**
  - `mem_o` = `req_i[grant_r]` with yumi forced to 0; `mem_addr_o` = `req_addr_i[grant_r]`.
  - `resp_o[grant_r].yumi` = `mem_i.yumi`.
  - If `mem_i.yumi` is seen, go to RESP.
  - If `req_i[grant_r].valid` drops before `mem_i.yumi` (requester withdrew), go to IDLE and advance rr_ptr_r.
- **RESP.**
  - `mem_o.valid` = 0, but address and wen stay held from the granted requester.
  - `resp_o[grant_r].valid` = `mem_i.valid`; `resp_o[grant_r].read_data` = `mem_i.read_data`.
  - `mem_o.yumi` = `req_i[grant_r].yumi`.
  - Stores also complete through RESP, because every transaction is acknowledged by `mem_i.valid`.
  - On `mem_i.valid & req_i[grant_r].yumi`, go to IDLE with rr_ptr_r <= (grant_r+1) mod num_req_p.
- **Non-granted slots.** `resp_o[k]` is all zeros (valid=0, yumi=0, read_data=0).
- **Watchdog.**
  - wd_cnt_r clears on entry to REQ and increments every cycle in REQ or RESP.
  - When wd_cnt_r == timeout_p, set timeout_o = 1, force state to IDLE, and advance rr_ptr_r.
  - No yumi is issued on that abort cycle.
  - timeout_o stays set until reset.
- `grant_o` = one-hot(grant_r) in REQ/RESP, 0 in IDLE.

## Timing
- **Reset values.** state_r=IDLE, grant_r=0, rr_ptr_r=0, wd_cnt_r=0, timeout_o=0. All `resp_o` and `mem_o` fields are 0, `mem_addr_o`=0, `grant_o`=0.
- **Grant latency.** A request valid in IDLE at cycle t is presented on `mem_o` at cycle t+1.
- **Handshakes are combinational pass-through within a cycle:**
  - `mem_i.yumi` reaches `resp_o.yumi` in the same cycle;
  - `mem_i.valid` and read_data reach `resp_o` in the same cycle;
  - `req_i.yumi` reaches `mem_o.yumi` in the same cycle.
- **Minimum transaction length.** IDLE(1) + REQ(>=1) + RESP(>=1). The best case is a new grant every 3 cycles.
- **Simultaneous events.**
  - `mem_i.yumi` and `mem_i.valid` in the same REQ cycle: only yumi is honoured; the response is taken in RESP.
  - Watchdog expiry on the same cycle as a handshake completion: completion wins, and timeout_o is not set.
- **Fairness.** A requester that is continuously valid waits at most num_req_p-1 transactions.
- **Reset mid-transaction.** State returns to IDLE next cycle with all outputs deasserted. Any outstanding memory response is dropped; the memory is reset with the tile.

## Test plan
- **Single store.** Only slot 0 valid, wen=1, addr=0x10, data=0xDEADBEEF. Expect:
  - `mem_o.valid` and `mem_addr_o`=0x10 one cycle later;
  - mem yumi then valid, with core yumi, returns the arbiter to IDLE;
  - `grant_o` = 01 throughout.
- **Round-robin.** Slots 0 and 1 valid continuously, memory responding in 1 cycle. Expect grants 0,1,0,1, one transaction every 3 cycles, and rr_ptr alternating.
- **Response routing.** Slot 1 load, memory returns read_data=0x12345678. Expect:
  - `resp_o[1].read_data`=0x12345678 with valid;
  - `resp_o[0]` all zeros.
- **Withdraw.** Slot 0 drops valid in REQ before `mem_i.yumi`. Expect:
  - IDLE next cycle, no `mem_o.valid` afterwards;
  - slot 1 (if valid) granted the cycle after.
- **Watchdog.** timeout_p=4, memory never yumis. Expect:
  - timeout_o=1 four cycles after REQ entry, state IDLE;
  - timeout_o held until reset, and subsequent transactions still work.
- **Reset mid-RESP.** Assert reset during RESP. Expect every output 0 the next cycle, then a normal grant after reset deasserts.
